// File: rtl/cpu_hatch_mem.sv
// rtl/cpu_hatch_mem.sv - hatch-side instruction memory with byte-stream program loader
module cpu_hatch_mem #(
    parameter int ADDR_BITS = 12
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [31:0] hatch_address,
    output logic [47:0] hatch_instruction,
    input  logic [7:0]  load_byte,
    input  logic        load_valid,
    output logic        load_ready,
    output logic        cpu_run,
    output logic        load_err,
    output logic [31:0] load_addr
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR0,
        S_ADDR1,
        S_ADDR2,
        S_ADDR3,
        S_CNT0,
        S_CNT1,
        S_DATA_LO,
        S_DATA_HI,
        S_COMMIT
    } state_e;

    logic [15:0] mem [DEPTH];

    state_e         state_q, state_d;
    logic [23:0]    addr_buf_q, addr_buf_d;
    logic [31:0]    load_addr_q, load_addr_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [7:0]     lo_q, lo_d;
    logic [7:0]     hi_q, hi_d;
    logic           run_q, run_d;
    logic           err_q, err_d;

    logic                 xfer;
    logic                 wr_en;
    logic [ADDR_BITS-1:0] rd_idx0, rd_idx1, rd_idx2;
    logic                 unused_addr_bits;

    // Upper address bits alias and bit 0 selects nothing in a halfword memory.
    assign unused_addr_bits = ^{hatch_address[31:ADDR_BITS+1], hatch_address[0]};

    assign rd_idx0 = hatch_address[ADDR_BITS:1];
    assign rd_idx1 = rd_idx0 + ADDR_BITS'(1);
    assign rd_idx2 = rd_idx0 + ADDR_BITS'(2);

    assign hatch_instruction = {mem[rd_idx0], mem[rd_idx1], mem[rd_idx2]};

    assign load_ready = rst_b && (state_q != S_COMMIT);
    assign xfer       = load_valid && load_ready;
    assign wr_en      = (state_q == S_COMMIT) && !run_q;

    assign cpu_run   = run_q;
    assign load_err  = err_q;
    assign load_addr = load_addr_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[load_addr_q[ADDR_BITS:1]] <= {hi_q, lo_q};
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= S_IDLE;
            addr_buf_q  <= '0;
            load_addr_q <= '0;
            cnt_q       <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            run_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_buf_q  <= addr_buf_d;
            load_addr_q <= load_addr_d;
            cnt_q       <= cnt_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            run_q       <= run_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_buf_d  = addr_buf_q;
        load_addr_d = load_addr_q;
        cnt_d       = cnt_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        run_d       = run_q;
        err_d       = err_q;

        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    case (load_byte)
                        8'h01:   state_d = S_ADDR0;
                        8'h02:   state_d = S_CNT0;
                        8'h03:   run_d   = 1'b1;
                        8'h04: begin
                            run_d = 1'b0;
                            err_d = 1'b0;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_ADDR0: if (xfer) begin addr_buf_d[7:0]   = load_byte; state_d = S_ADDR1; end
            S_ADDR1: if (xfer) begin addr_buf_d[15:8]  = load_byte; state_d = S_ADDR2; end
            S_ADDR2: if (xfer) begin addr_buf_d[23:16] = load_byte; state_d = S_ADDR3; end
            S_ADDR3: begin
                if (xfer) begin
                    load_addr_d = {load_byte, addr_buf_q[23:1], 1'b0};
                    state_d     = S_IDLE;
                end
            end
            S_CNT0: if (xfer) begin cnt_d = {8'h00, load_byte}; state_d = S_CNT1; end
            S_CNT1: begin
                if (xfer) begin
                    cnt_d   = {load_byte, cnt_q[7:0]};
                    state_d = ({load_byte, cnt_q[7:0]} == 16'h0000) ? S_IDLE : S_DATA_LO;
                end
            end
            S_DATA_LO: if (xfer) begin lo_d = load_byte; state_d = S_DATA_HI; end
            S_DATA_HI: if (xfer) begin hi_d = load_byte; state_d = S_COMMIT; end
            S_COMMIT: begin
                // Pointer advances even for discarded writes so the host stream stays framed.
                if (run_q) begin
                    err_d = 1'b1;
                end
                load_addr_d = load_addr_q + 32'd2;
                cnt_d       = cnt_q - 16'd1;
                state_d     = (cnt_q == 16'd1) ? S_IDLE : S_DATA_LO;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cpu_hatch_mem.sv
// tb/tb_cpu_hatch_mem.sv - self-checking bench for cpu_hatch_mem
module tb_cpu_hatch_mem;

    localparam int AB    = 12;
    localparam int DEPTH = 1 << AB;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic [31:0] hatch_address = '0;
    logic [47:0] hatch_instruction;
    logic [7:0]  load_byte = '0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic        cpu_run;
    logic        load_err;
    logic [31:0] load_addr;

    cpu_hatch_mem #(.ADDR_BITS(AB)) dut (
        .clk               (clk),
        .rst_b             (rst_b),
        .hatch_address     (hatch_address),
        .hatch_instruction (hatch_instruction),
        .load_byte         (load_byte),
        .load_valid        (load_valid),
        .load_ready        (load_ready),
        .cpu_run           (cpu_run),
        .load_err          (load_err),
        .load_addr         (load_addr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [15:0] m_mem   [DEPTH];
    logic        m_known [DEPTH];
    logic [31:0] m_addr = '0;
    logic        m_run = 1'b0;
    logic        m_err = 1'b0;
    logic        model_valid = 1'b0;

    int low_cnt = 0;
    int cur_run = 0;
    int max_run = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_b) begin
            if (!load_ready) begin
                low_cnt++;
                cur_run++;
                if (cur_run > max_run) max_run = cur_run;
            end else begin
                cur_run = 0;
            end
        end
    end

    // Compare DUT against the command-level model whenever the bench is between commands.
    always @(negedge clk) begin
        if (model_valid && rst_b) begin
            logic [47:0] exp_i;
            logic [47:0] mask;
            int base;
            base  = int'(hatch_address[AB:1]);
            exp_i = '0;
            mask  = '0;
            for (int k = 0; k < 3; k++) begin
                int ix;
                ix = (base + k) % DEPTH;
                if (m_known[ix]) begin
                    exp_i[47-16*k -: 16] = m_mem[ix];
                    mask[47-16*k -: 16]  = 16'hFFFF;
                end
            end
            checks++;
            if (load_addr !== m_addr || cpu_run !== m_run || load_err !== m_err ||
                load_ready !== 1'b1 || ((hatch_instruction & mask) !== exp_i)) begin
                failures++;
                $display("FAIL model t=%0t: got addr=%0h run=%0b err=%0b rdy=%0b instr=%0h expected addr=%0h run=%0b err=%0b rdy=1 instr=%0h mask=%0h",
                         $time, load_addr, cpu_run, load_err, load_ready, hatch_instruction,
                         m_addr, m_run, m_err, exp_i, mask);
            end
        end
    end

    // Called at #1 after a posedge; returns at #1 after the transfer edge, valid left high.
    task automatic send_byte(input logic [7:0] b);
        int budget;
        budget     = 0;
        load_byte  = b;
        load_valid = 1'b1;
        while (!load_ready && budget < 8) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (!load_ready) begin
            checks++;
            failures++;
            $display("FAIL handshake_timeout: got load_ready=0 expected 1 within 8 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic begin_cmd();
        model_valid = 1'b0;
    endtask

    task automatic finish_cmd();
        load_valid = 1'b0;
        @(posedge clk);
        #1;
        model_valid = 1'b1;
    endtask

    task automatic cmd_addr(input logic [31:0] a);
        begin_cmd();
        send_byte(8'h01);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        m_addr = {a[31:1], 1'b0};
        finish_cmd();
    endtask

    task automatic cmd_write(input logic [15:0] hw [4], input int n);
        begin_cmd();
        send_byte(8'h02);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        for (int i = 0; i < n; i++) begin
            send_byte(hw[i][7:0]);
            send_byte(hw[i][15:8]);
        end
        for (int i = 0; i < n; i++) begin
            if (m_run) begin
                m_err = 1'b1;
            end else begin
                m_mem[int'(m_addr[AB:1])]   = hw[i];
                m_known[int'(m_addr[AB:1])] = 1'b1;
            end
            m_addr = m_addr + 32'd2;
        end
        finish_cmd();
    endtask

    task automatic cmd_byte(input logic [7:0] b);
        begin_cmd();
        send_byte(b);
        if (b == 8'h03) m_run = 1'b1;
        if (b == 8'h04) begin
            m_run = 1'b0;
            m_err = 1'b0;
        end
        finish_cmd();
    endtask

    task automatic model_reset();
        m_addr = '0;
        m_run  = 1'b0;
        m_err  = 1'b0;
    endtask

    initial begin
        logic [15:0] hw [4];
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]   = '0;
            m_known[i] = 1'b0;
        end

        #1;
        chk("reset_ready", load_ready, 0);
        chk("reset_run", cpu_run, 0);
        chk("reset_err", load_err, 0);
        chk("reset_addr", load_addr, 0);
        #20;
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_ready", load_ready, 1);
        model_valid = 1'b1;

        // Load three halfwords at 0x10 with valid held through the data phase.
        cmd_addr(32'h0000_0010);
        hatch_address = 32'h10;
        hw = '{16'h1234, 16'h5678, 16'h9ABC, 16'h0000};
        low_cnt = 0;
        max_run = 0;
        cmd_write(hw, 3);
        chk("hs_low_cycles", low_cnt, 3);
        chk("hs_low_run", max_run, 1);
        chk("load_addr_after_load", load_addr, 32'h16);
        chk("instr_0x10", hatch_instruction, 48'h1234_5678_9ABC);
        hatch_address = 32'h11;
        #1;
        chk("instr_0x11", hatch_instruction, 48'h1234_5678_9ABC);

        // Wrap around the top of the memory.
        cmd_addr(32'h0000_1FFE);
        hw = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'h0000};
        cmd_write(hw, 3);
        hatch_address = 32'h1FFE;
        #1;
        chk("wrap_instr", hatch_instruction, 48'hAAAA_BBBB_CCCC);
        chk("wrap_addr", load_addr, 32'h2004);
        hatch_address = 32'hABC0_3FFE;
        #1;
        chk("alias_instr", hatch_instruction, 48'hAAAA_BBBB_CCCC);

        // Zero count leaves everything untouched.
        begin_cmd();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h00);
        finish_cmd();
        hatch_address = 32'h10;
        #1;
        chk("zero_addr", load_addr, 32'h2004);
        chk("zero_instr", hatch_instruction, 48'h1234_5678_9ABC);

        // Unknown command ignored, then 0x03/0x04 as data bytes.
        cmd_byte(8'h7F);
        cmd_addr(32'h0000_0020);
        chk("after_unknown_addr", load_addr, 32'h20);
        hw = '{16'h0403, 16'h0000, 16'h0000, 16'h0000};
        cmd_write(hw, 1);
        hatch_address = 32'h20;
        #1;
        chk("data_0403_instr_hi", hatch_instruction[47:32], 16'h0403);
        chk("data_0403_run", cpu_run, 0);

        // Writes while running are discarded but still advance the pointer.
        cmd_addr(32'h0000_0010);
        cmd_byte(8'h03);
        chk("run_set", cpu_run, 1);
        hw = '{16'hBEEF, 16'h0000, 16'h0000, 16'h0000};
        cmd_write(hw, 1);
        hatch_address = 32'h10;
        #1;
        chk("run_write_err", load_err, 1);
        chk("run_write_addr", load_addr, 32'h12);
        chk("run_write_mem", hatch_instruction, 48'h1234_5678_9ABC);
        cmd_byte(8'h04);
        chk("halt_run", cpu_run, 0);
        chk("halt_err", load_err, 0);

        // Reset mid address command with run and err set.
        cmd_byte(8'h03);
        hw = '{16'h1111, 16'h0000, 16'h0000, 16'h0000};
        cmd_write(hw, 1);
        begin_cmd();
        send_byte(8'h01);
        send_byte(8'h55);
        rst_b = 1'b0;
        load_valid = 1'b0;
        #1;
        chk("mid_reset_run", cpu_run, 0);
        chk("mid_reset_err", load_err, 0);
        chk("mid_reset_addr", load_addr, 0);
        chk("mid_reset_ready", load_ready, 0);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        chk("mid_reset_release_ready", load_ready, 1);
        model_valid = 1'b1;

        // Partial halfword aborted by reset is never written.
        cmd_addr(32'h0000_0010);
        begin_cmd();
        send_byte(8'h02);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h55);
        rst_b = 1'b0;
        load_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        model_valid = 1'b1;
        hatch_address = 32'h10;
        #1;
        chk("partial_not_written", hatch_instruction, 48'h1234_5678_9ABC);
        chk("partial_reset_addr", load_addr, 0);

        // New command works after the aborted one.
        cmd_addr(32'h0000_0100);
        chk("post_abort_addr", load_addr, 32'h100);
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_hatch_mem.md
Name: cpu_hatch_mem

Overview:
- Instruction-memory responder on the hatch side of the fetch interface. It answers the fetch unit's halfword-aligned address with a 48-bit instruction assembled from three consecutive 16-bit words in the same cycle.
- Also contains a byte-stream loader FSM. A host uses it to set a load pointer, write program halfwords, and start or halt the CPU through a run output.

Parameters:
- ADDR_BITS, 12, number of halfword-index bits; memory holds 2^ADDR_BITS halfwords (default 8 KiB).

Ports:
- clk  input  1  clock
- rst_b  input  1  asynchronous active-low reset
- hatch_address  input  32  byte address from fetch; bit 0 is ignored
- hatch_instruction  output  48  instruction at hatch_address, combinational
- load_byte  input  8  host stream byte
- load_valid  input  1  load_byte is valid this cycle
- load_ready  output  1  block accepts load_byte this cycle
- cpu_run  output  1  1 = CPU released from halt; drives CPU rst_b gating
- load_err  output  1  sticky: a write was attempted while cpu_run=1
- load_addr  output  32  current load pointer (byte address), for debug

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_b).

Read path:
- idx = hatch_address[ADDR_BITS:1].
- hatch_instruction = {mem[idx], mem[idx+1], mem[idx+2]}, so mem[idx] occupies bits [47:32].
- Index additions wrap modulo 2^ADDR_BITS.
- Address bits above ADDR_BITS are ignored, so the memory aliases.
- Zero-latency asynchronous read. The fetch unit registers the value at the next clk edge.
- A write in the same cycle to a read halfword: the read returns the old contents; the new value is visible from the next cycle.

Reset:
- FSM goes to IDLE; load_addr=0; cpu_run=0; load_err=0; byte and count registers = 0.
- load_ready=0 while rst_b=0.
- Memory contents are not reset.
- Reset mid-command aborts the command. A partially received halfword is never written.

Handshake:
- A byte transfers on a clk edge where load_valid=1 and load_ready=1.
- load_ready=1 in every state except WRITE_COMMIT, where it is 0 for exactly one cycle.

FSM states:
- IDLE: accepted byte is a command.
  - 0x01 goes to ADDR0.
  - 0x02 goes to CNT0.
  - 0x03 sets cpu_run=1 and stays in IDLE.
  - 0x04 clears cpu_run, clears load_err, and stays in IDLE.
  - Any other byte is discarded; stay in IDLE.
- ADDR0..ADDR3: four bytes, little-endian, form the new load_addr. load_addr[0] is forced to 0. load_addr is updated after the fourth byte; return to IDLE.
- CNT0, CNT1: 16-bit halfword count N, little-endian.
  - N=0 returns to IDLE.
  - Otherwise go to DATA_LO.
- DATA_LO: latch the low byte; go to DATA_HI.
- DATA_HI: latch the high byte; go to WRITE_COMMIT.
- WRITE_COMMIT (one cycle):
  - If cpu_run=0: mem[load_addr[ADDR_BITS:1]] <= {hi,lo}.
  - If cpu_run=1: discard the data and set load_err=1.
  - In both cases: load_addr += 2 (32-bit wrap); N -= 1.
  - If N becomes 0, go to IDLE; otherwise go to DATA_LO.

Other rules:
- load_addr advances even when a write is discarded, so the stream stays framed.
- cpu_run changes only in IDLE on 0x03 or 0x04.
- Command bytes 0x03 and 0x04 are only meaningful in IDLE. In any other state they are data.

Test Plan:
- Reset: assert rst_b=0 mid-stream -> cpu_run=0, load_err=0, load_addr=0, load_ready=0; after release, load_ready=1 and FSM in IDLE.
- Load and read:
  - Stimulus: stream 01 10 00 00 00, 02 03 00, then 34 12 78 56 BC 9A; drive hatch_address=0x10.
  - Required: load_addr=0x16; hatch_instruction=48'h1234_5678_9ABC; hatch_address=0x11 gives the same result.
- Wrap:
  - Stimulus: ADDR_BITS=12; write three halfwords AAAA, BBBB, CCCC starting at byte address 0x1FFE; read hatch_address=0x1FFE.
  - Required: bits [47:32]=AAAA; bits [31:16]=mem[0]=BBBB.
- Zero count: 02 00 00 -> FSM returns to IDLE; memory unchanged; load_addr unchanged.
- Write while running:
  - Stimulus: 03, then 02 01 00 EF BE.
  - Required: memory unchanged; load_err=1; load_addr advanced by 2.
  - Then send 04 -> cpu_run=0 and load_err=0.
- Handshake and unknown command:
  - Hold load_valid=1 through a write -> load_ready is 0 for exactly one cycle per halfword.
  - Byte 0x7F in IDLE -> ignored; the next 0x01 command works normally.
